// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to implement the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module mdu_hilo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] hilo;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   num, den;
    logic [WIDTH-1:0]   q_mag, r_mag;
    logic [WIDTH-1:0]   quot, rem;
    logic [2*WIDTH-1:0] div_res;

    assign hilo   = {hi_q, lo_q};
    assign prod_s = $signed({{WIDTH{operand1[WIDTH-1]}}, operand1})
                  * $signed({{WIDTH{operand2[WIDTH-1]}}, operand2});
    assign prod_u = {{WIDTH{1'b0}}, operand1} * {{WIDTH{1'b0}}, operand2};

    // One unsigned divider serves both modes; signed division works on magnitudes
    // and restores signs afterwards (MIN/-1 falls out naturally as MIN rem 0).
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & operand1[WIDTH-1];
    assign b_neg      = div_signed & operand2[WIDTH-1];
    assign a_mag      = a_neg ? -operand1 : operand1;
    assign b_mag      = b_neg ? -operand2 : operand2;
    assign num        = a_mag;
    assign den        = b_mag;
    assign q_mag      = (den == '0) ? '0 : num / den;
    assign r_mag      = (den == '0) ? '0 : num % den;
    assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem        = a_neg ? -r_mag : r_mag;
    // Divide by zero still runs full latency but commits the unchanged HI/LO.
    assign div_res    = (operand2 == '0) ? hilo : {rem, quot};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT: begin
                            pend_d  = prod_s;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = prod_u;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d  = div_res;
                            cnt_d   = DIV_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = operand1;
                        OP_MTLO: lo_d = operand1;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            pend_d  = hilo + prod_s;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MADDU: begin
                            pend_d  = hilo + prod_u;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MSUB: begin
                            pend_d  = hilo - prod_s;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
                        OP_MSUBU: begin
                            pend_d  = hilo - prod_u;
                            cnt_d   = MUL_LOAD;
                            state_d = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed scoreboard bench for mdu_hilo (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_hilo;

    localparam int unsigned W    = 32;
    localparam int          NMUL = 5;
    localparam int          NDIV = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] operand1, operand2;
    logic         cancel;
    logic         busy;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] sb[$];
    logic [31:0] mhi, mlo;

    mdu_hilo #(.WIDTH(W), .MUL_CYCLES(NMUL), .DIV_CYCLES(NDIV)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb_, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = hl;
        case (o)
            4'd1: res = 64'(sa * sb_);
            4'd2: res = ua * ub;
            4'd3: if (b != 0) begin
                q = sa / sb_;
                r = sa % sb_;
                res = {r[31:0], q[31:0]};
            end
            4'd4: if (b != 0) begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                res = {r[31:0], q[31:0]};
            end
            4'd5: res = {a, hl[31:0]};
            4'd6: res = {hl[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  res = hl + 64'(sa * sb_);
            4'd8:  res = hl + ua * ub;
            4'd9:  res = hl - 64'(sa * sb_);
            4'd10: res = hl - ua * ub;
`endif
            default: res = hl;
        endcase
        return res;
    endfunction

    function automatic int latency(input logic [3:0] o);
        case (o)
            4'd1, 4'd2: return NMUL;
            4'd3, 4'd4: return NDIV;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return NMUL;
`endif
            default: return 0;
        endcase
    endfunction

    // Issue one op, count busy cycles against expected latency, then compare HI/LO.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int cnt;
        sb.push_back(model(o, a, b, {mhi, mlo}));
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        step();
        start = 1'b0; op = 4'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        check({tag, ".busy_cycles"}, 64'(cnt), 64'(latency(o)));
        e = sb.pop_front();
        check({tag, ".hi"}, {32'b0, hi}, {32'b0, e[63:32]});
        check({tag, ".lo"}, {32'b0, lo}, {32'b0, e[31:0]});
        {mhi, mlo} = e;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 4'd0;
        operand1 = '0; operand2 = '0; cancel = 1'b0;
        mhi = '0; mlo = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("reset.busy", {63'b0, busy}, 64'd0);
        check("reset.hi", {32'b0, hi}, 64'd0);
        check("reset.lo", {32'b0, lo}, 64'd0);

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_neg.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("divu_7_2", 4'd4, 32'd7, 32'd2);
        check("divu_7_2.const", {hi, lo}, {32'd1, 32'd3});
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg.const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_min", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min.const", {hi, lo}, {32'h0, 32'h8000_0000});
        run_op("div_posneg", 4'd3, 32'd100, 32'hFFFF_FFF9);
        run_op("multu_big", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_negneg", 4'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("div_zero", 4'd3, 32'd55, 32'd0);
        run_op("divu_zero", 4'd4, 32'hDEAD_BEEF, 32'd0);
        run_op("reserved", 4'd13, 32'd1, 32'd1);

        // MTHI, then MULTU cancelled on its third busy cycle; a start mid-run is ignored.
        run_op("mthi", 4'd5, 32'h0000_1234, 32'd0);
        start = 1'b1; op = 4'd2; operand1 = 32'd2; operand2 = 32'd3;
        step();
        start = 1'b1; op = 4'd6; operand1 = 32'hDEAD_0000;
        check("cancel.busy1", {63'b0, busy}, 64'd1);
        step();
        start = 1'b0; op = 4'd0;
        check("ignore_start.lo", {32'b0, lo}, {32'b0, mlo});
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel.busy_low", {63'b0, busy}, 64'd0);
        repeat (6) step();
        check("cancel.hi", {32'b0, hi}, 64'h1234);
        check("cancel.lo", {32'b0, lo}, {32'b0, mlo});

        // Cancel on the would-be commit edge.
        start = 1'b1; op = 4'd1; operand1 = 32'd9; operand2 = 32'd9;
        step();
        start = 1'b0;
        repeat (NMUL - 1) step();
        check("cancel_last.busy", {63'b0, busy}, 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_last.busy_low", {63'b0, busy}, 64'd0);
        check("cancel_last.hilo", {hi, lo}, {mhi, mlo});

        // Cancel together with start in IDLE: nothing issues, MTLO included.
        start = 1'b1; cancel = 1'b1; op = 4'd6; operand1 = 32'hAAAA_5555;
        step();
        op = 4'd1;
        step();
        start = 1'b0; cancel = 1'b0;
        check("cancel_idle.busy", {63'b0, busy}, 64'd0);
        check("cancel_idle.hilo", {hi, lo}, {mhi, mlo});

        // Accumulate sequence.
        run_op("acc.mthi0", 4'd5, 32'd0, 32'd0);
        run_op("acc.mtlo10", 4'd6, 32'd10, 32'd0);
        run_op("acc.madd", 4'd7, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        check("acc.madd.const", {hi, lo}, {32'd0, 32'd22});
        run_op("acc.msub", 4'd9, 32'hFFFF_FFFF, 32'd5);
        run_op("acc.maddu", 4'd8, 32'hFFFF_FFFF, 32'h2);
        run_op("acc.msubu", 4'd10, 32'h8000_0000, 32'h4);
`else
        check("acc.madd.const", {hi, lo}, {32'd0, 32'd10});
`endif

        // Asynchronous reset mid-run.
        start = 1'b1; op = 4'd2; operand1 = 32'd7; operand2 = 32'd7;
        step();
        start = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("async_rst.busy", {63'b0, busy}, 64'd0);
        check("async_rst.hilo", {hi, lo}, 64'd0);
        step();
        reset_n = 1'b1;
        mhi = '0; mlo = '0;
        repeat (NMUL + 1) step();
        check("async_rst.no_commit", {hi, lo}, 64'd0);
        run_op("post_rst", 4'd2, 32'd6, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
